// File: rtl/str_dsp_pkg.sv
// Shared helpers for the LPDAQ stream stages:
// constant math, parameter checks, sample type.
package str_dsp_pkg;

  localparam int SAMPLE_DW = 12;

  typedef logic signed [SAMPLE_DW-1:0] sample_t;

  // floor(log2(n)), n >= 1
  function automatic int log2(input int n);
    int r;
    r = 0;
    while ((n >> (r + 1)) > 0) r++;
    return r;
  endfunction

  // ceil(log2(n)), n >= 1
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic bit is_pow2(input int n);
    return (n > 0) && ((n & (n - 1)) == 0);
  endfunction

  function automatic bit ratio_ok(input int r);
    return r >= 1;
  endfunction

  function automatic bit avg_ok(input int r, input int avg);
    return (avg == 0) || is_pow2(r);
  endfunction

  function automatic bit phase_ok(input int r, input int phase);
    return (phase >= 0) && (phase < r);
  endfunction

endpackage

// File: rtl/str_skid_buf.sv
// Two-entry AXI-stream register slice; in_ready
// comes straight from a flop.
module str_skid_buf
  import str_dsp_pkg::*;
#(
  parameter int DW = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  input  logic          out_ready
);

  logic          main_v;
  logic          skid_v;
  logic [DW-1:0] main_d;
  logic [DW-1:0] skid_d;
  logic          drain;

  assign drain     = main_v & out_ready;
  assign in_ready  = ~skid_v;
  assign out_valid = main_v;
  assign out_data  = main_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
      main_d <= '0;
      skid_d <= '0;
    end else if (drain) begin
      if (skid_v) begin
        main_d <= skid_d;
        skid_v <= in_valid;
        if (in_valid) skid_d <= in_data;
      end else if (in_valid) begin
        main_d <= in_data;
      end else begin
        main_v <= 1'b0;
      end
    end else if (in_valid) begin
      // upstream only pushes while skid is free
      if (!main_v) begin
        main_v <= 1'b1;
        main_d <= in_data;
      end else begin
        skid_v <= 1'b1;
        skid_d <= in_data;
      end
    end
  end

endmodule

// File: rtl/str_decim.sv
// Decimate-by-R stream stage: pick one sample
// per frame or emit the boxcar mean.
module str_decim
  import str_dsp_pkg::*;
#(
  parameter int DW    = 12,
  parameter int R     = 4,
  parameter int AVG   = 0,
  parameter int PHASE = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          sync,
  input  logic [DW-1:0] s_axis_tdata,
  input  logic          s_axis_tvalid,
  output logic          s_axis_tready,
  output logic [DW-1:0] m_axis_tdata,
  output logic          m_axis_tvalid,
  input  logic          m_axis_tready
);

  localparam int L  = log2(R);
  localparam int CB = clog2(R);
  localparam int CW = (CB > 1) ? CB : 1;
  localparam int AW = DW + L;

  localparam logic [CW-1:0] LAST = CW'(R - 1);

  if (!ratio_ok(R)) begin : g_chk_r
    $fatal(1, "str_decim: R must be >= 1");
  end
  if (!avg_ok(R, AVG)) begin : g_chk_avg
    $fatal(1, "str_decim: AVG needs R a power of 2");
  end
  if (!phase_ok(R, PHASE)) begin : g_chk_ph
    $fatal(1, "str_decim: PHASE must be < R");
  end

  logic [CW-1:0] cnt;
  logic [CW-1:0] idx;
  logic          ish;
  logic          in_ready;
  logic          push;
  logic [DW-1:0] push_data;

  assign s_axis_tready = in_ready;
  assign ish = s_axis_tvalid & in_ready;
  // sync makes the current input index 0
  assign idx = sync ? '0 : cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (ish) begin
      cnt <= (idx == LAST) ? '0 : idx + CW'(1);
    end else if (sync) begin
      cnt <= '0;
    end
  end

  if (AVG != 0) begin : g_avg
    logic signed [AW-1:0] acc;
    logic signed [AW-1:0] smp;
    logic signed [AW-1:0] sum;

    assign smp = AW'($signed(s_axis_tdata));
    assign sum = (idx == '0) ? smp : acc + smp;
    assign push = ish && (idx == LAST);
    // arithmetic shift floors; mean always fits DW
    assign push_data = DW'(sum >>> L);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        acc <= '0;
      end else if (ish) begin
        acc <= (idx == LAST) ? '0 : sum;
      end else if (sync) begin
        acc <= '0;
      end
    end
  end else begin : g_pick
    assign push = ish && (idx == CW'(PHASE));
    assign push_data = s_axis_tdata;
  end

  str_skid_buf #(
    .DW(DW)
  ) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (push),
    .in_data  (push_data),
    .in_ready (in_ready),
    .out_valid(m_axis_tvalid),
    .out_data (m_axis_tdata),
    .out_ready(m_axis_tready)
  );

endmodule
